// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing one UART TX core among NREQ byte requesters.
// Picks the first pending requester at or above the rotating pointer, latches
// its byte, strobes the TX core for one cycle, then waits for the frame-done
// tick before serving anyone else.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to abort WAIT after
// TO_TICKS s_tick periods without a done tick (pulses timeout_err).
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   s_tick        oversampling tick (used only by the timeout feature)
//   req, din      per-requester level request and byte (din[i*DBIT +: DBIT])
//   ack           one-cycle pulse to the requester whose byte was accepted
//   tx_start      one-cycle start strobe to the TX core
//   tx_din        byte to the TX core, stable from LAUNCH through WAIT
//   tx_done_tick  TX core frame-complete pulse
//   busy          high while a frame is being launched or transmitted
//   grant_id      index of the current or last granted requester
//   timeout_err   one-cycle pulse when WAIT is aborted (timeout build only)
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DBIT     = 8,
  parameter int TO_TICKS = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tick,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBIT-1:0]    din,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                    timeout_err
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [DBIT-1:0]   tx_din_q, tx_din_d;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic [ID_W-1:0]   next_ptr;
  logic              abort;

  // Rotating priority search: first set bit at ptr, ptr+1, ... modulo NREQ.
  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign next_ptr = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;

  logic [CNT_W-1:0] to_cnt_q;
  logic             timeout_q;

  // Done wins over a coincident terminal tick.
  assign abort = (state_q == WAIT) && s_tick && !tx_done_tick &&
                 (to_cnt_q == CNT_W'(TO_TICKS - 1));

  // Counter is cleared while in LAUNCH so it starts at 0 on entry to WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (state_q == LAUNCH)
        to_cnt_q <= '0;
      else if (state_q == WAIT && s_tick)
        to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
  assign abort         = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    tx_din_d = tx_din_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = sel;
          tx_din_d = din[int'(sel)*DBIT +: DBIT];
          state_d  = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (tx_done_tick || abort) begin
          ptr_d   = next_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      tx_din_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      tx_din_q <= tx_din_d;
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    ack = '0;
    if (state_q == LAUNCH) ack[grant_q] = 1'b1;
  end

  assign tx_start = (state_q == LAUNCH);
  assign busy     = (state_q == LAUNCH) || (state_q == WAIT);
  assign grant_id = grant_q;
  assign tx_din   = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NREQ=4, DBIT=8, TO_TICKS=16).
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tick;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TO_TICKS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .req          (req),
    .din          (din),
    .ack          (ack),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic tick_pulse();
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
    step();
  endtask

  // Bounded wait for the start strobe; an expired bound shows as a failed check.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check(tag, {31'b0, tx_start}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; s_tick = 1'b0; req = 4'b0; din = 32'b0; tx_done_tick = 1'b0;
    step();
    step();
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_ack", {28'b0, ack}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_grant", {30'b0, grant_id}, 32'd0);
    check("rst_tx_din", {24'b0, tx_din}, 32'd0);
    check("rst_timeout", {31'b0, timeout_err}, 32'd0);
    reset = 1'b0;
    step();

    // Single request on requester 2: start/ack one cycle after req is seen.
    din[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    check("single_start", {31'b0, tx_start}, 32'd1);
    check("single_ack", {28'b0, ack}, 32'h4);
    check("single_tx_din", {24'b0, tx_din}, 32'hA5);
    check("single_grant", {30'b0, grant_id}, 32'd2);
    check("single_busy", {31'b0, busy}, 32'd1);
    req = 4'b0;
    step();
    check("single_wait_start", {31'b0, tx_start}, 32'd0);
    check("single_wait_ack", {28'b0, ack}, 32'd0);
    check("single_wait_busy", {31'b0, busy}, 32'd1);
    step(); step(); step();
    check("single_hold_busy", {31'b0, busy}, 32'd1);
    done_pulse();
    check("single_done_busy", {31'b0, busy}, 32'd0);
    step();
    check("single_idle_start", {31'b0, tx_start}, 32'd0);

    // Done tick in IDLE and in LAUNCH must be ignored. Serves requester 3.
    done_pulse();
    check("idle_done_busy", {31'b0, busy}, 32'd0);
    din[31:24] = 8'h3C;
    req = 4'b1000;
    step();
    check("r3_start", {31'b0, tx_start}, 32'd1);
    check("r3_grant", {30'b0, grant_id}, 32'd3);
    check("r3_tx_din", {24'b0, tx_din}, 32'h3C);
    tx_done_tick = 1'b1;
    req = 4'b0;
    step();
    tx_done_tick = 1'b0;
    check("launch_done_ignored", {31'b0, busy}, 32'd1);
    step();
    check("launch_done_still_wait", {31'b0, busy}, 32'd1);
    done_pulse();
    check("r3_done_busy", {31'b0, busy}, 32'd0);

    // Pointer wrap: after serving 3, req=1001 grants 0 before 3.
    din = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1001;
    step();
    check("wrap_first_grant", {30'b0, grant_id}, 32'd0);
    check("wrap_first_ack", {28'b0, ack}, 32'h1);
    check("wrap_first_byte", {24'b0, tx_din}, 32'h10);
    req = 4'b1000;
    step();
    done_pulse();
    wait_start("wrap_second_start");
    check("wrap_second_grant", {30'b0, grant_id}, 32'd3);
    check("wrap_second_byte", {24'b0, tx_din}, 32'h13);
    req = 4'b0;
    step();
    done_pulse();

    // Round-robin with all pending: 0,1,2,3,0 and a 2-cycle done-to-start gap.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("rr%0d_start", i));
      check($sformatf("rr%0d_grant", i), {30'b0, grant_id}, 32'(i % 4));
      check($sformatf("rr%0d_byte", i), {24'b0, tx_din}, 32'(8'h10 + i % 4));
      check($sformatf("rr%0d_ack", i), {28'b0, ack}, 32'(1 << (i % 4)));
      repeat (19) step();
      if (i == 4) req = 4'b0;
      done_pulse();
      step();
      check($sformatf("rr%0d_gap", i), {31'b0, tx_start}, (i < 4) ? 32'd1 : 32'd0);
    end

    // Early drop: requester 1 withdraws in the cycle after selection.
    din[15:8] = 8'h5A;
    req = 4'b0010;
    step();
    req = 4'b0;
    din[15:8] = 8'hFF;
    check("drop_start", {31'b0, tx_start}, 32'd1);
    check("drop_ack", {28'b0, ack}, 32'h2);
    check("drop_grant", {30'b0, grant_id}, 32'd1);
    check("drop_byte", {24'b0, tx_din}, 32'h5A);
    step();
    check("drop_byte_held", {24'b0, tx_din}, 32'h5A);
    check("drop_busy", {31'b0, busy}, 32'd1);
    done_pulse();

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Timeout: 16th s_tick in WAIT aborts with a one-cycle timeout_err.
    din[23:16] = 8'h77;
    req = 4'b0100;
    step();
    check("to_grant", {30'b0, grant_id}, 32'd2);
    req = 4'b0;
    step();
    repeat (15) tick_pulse();
    check("to_before_busy", {31'b0, busy}, 32'd1);
    check("to_before_err", {31'b0, timeout_err}, 32'd0);
    s_tick = 1'b1;
    step();
    s_tick = 1'b0;
    check("to_err_pulse", {31'b0, timeout_err}, 32'd1);
    check("to_idle", {31'b0, busy}, 32'd0);
    step();
    check("to_err_one_cycle", {31'b0, timeout_err}, 32'd0);
    req = 4'b0101;
    step();
    check("to_ptr_advanced", {30'b0, grant_id}, 32'd0);
    req = 4'b0;
    step();
    repeat (15) tick_pulse();
    s_tick = 1'b1;
    tx_done_tick = 1'b1;
    step();
    s_tick = 1'b0;
    tx_done_tick = 1'b0;
    check("coincide_no_err", {31'b0, timeout_err}, 32'd0);
    check("coincide_idle", {31'b0, busy}, 32'd0);
    step();
    check("coincide_no_err_later", {31'b0, timeout_err}, 32'd0);
`endif

    // Serve requester 2 so the pointer sits at 3 before the reset test.
    din[23:16] = 8'hA5;
    req = 4'b0100;
    step();
    check("pre_rst_grant2", {30'b0, grant_id}, 32'd2);
    req = 4'b0;
    step();
    done_pulse();
    req = 4'b1000;
    step();
    check("pre_rst_grant3", {30'b0, grant_id}, 32'd3);
    req = 4'b0;
    step();
`ifndef UART_TX_ARB_TIMEOUT_EN
    repeat (20) tick_pulse();
    check("no_to_busy", {31'b0, busy}, 32'd1);
    check("no_to_err", {31'b0, timeout_err}, 32'd0);
`endif

    // Asynchronous reset in WAIT: outputs clear without waiting for an edge.
    reset = 1'b1;
    #1;
    check("wrst_busy", {31'b0, busy}, 32'd0);
    check("wrst_tx_start", {31'b0, tx_start}, 32'd0);
    check("wrst_ack", {28'b0, ack}, 32'd0);
    check("wrst_grant", {30'b0, grant_id}, 32'd0);
    check("wrst_tx_din", {24'b0, tx_din}, 32'd0);
    check("wrst_timeout", {31'b0, timeout_err}, 32'd0);
    step();
    reset = 1'b0;
    // ptr back at 0 grants 1 for req=1010; a stale ptr of 3 would grant 3.
    req = 4'b1010;
    step();
    check("post_rst_start", {31'b0, tx_start}, 32'd1);
    check("post_rst_grant", {30'b0, grant_id}, 32'd1);
    check("post_rst_ack", {28'b0, ack}, 32'h2);
    req = 4'b0;
    step();
    done_pulse();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter core among `NREQ` byte requesters. It picks one pending requester, latches its byte, issues a single-cycle start to the transmitter, and waits for the transmitter's done tick before granting the next requester. It sits between client logic (command responders, status reporters, loopback paths) and the UART TX serializer, which runs on the same `clk` and `s_tick` oversampling tick as the receiver.

## Interface
- `NREQ`, 4: number of requesters, ≥1
- `DBIT`, 8: data bits per frame; must match the TX core
- `TO_TICKS`, 2048: `s_tick` periods allowed in WAIT before abort; only used with the timeout feature
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `s_tick` in 1: oversampling tick, one `clk` wide
- `req` in NREQ: level request; bit i = requester i has a byte pending
- `din` in NREQ*DBIT: requester i byte at `[i*DBIT +: DBIT]`
- `ack` out NREQ: one-cycle pulse on bit i when requester i's byte is accepted
- `tx_start` out 1: one-cycle start strobe to the TX core
- `tx_din` out DBIT: byte to the TX core; held stable from LAUNCH through WAIT
- `tx_done_tick` in 1: TX core frame-complete pulse
- `busy` out 1: high in LAUNCH and WAIT
- `grant_id` out max(1,$clog2(NREQ)): index of the current or last granted requester
- `timeout_err` out 1: one-cycle pulse on a WAIT abort (timeout build only)

## Operation
- States: IDLE, LAUNCH, WAIT. Encoding is 2 bits; the unused code returns to IDLE.
- **IDLE**
  - If `req != 0`, select the first set bit searching upward from `ptr`, wrapping modulo NREQ.
  - Register `grant_id = sel` and `tx_din = din[sel]`, then go to LAUNCH.
- **LAUNCH** (exactly one cycle)
  - `tx_start = 1` and `ack[sel] = 1`, then go to WAIT.
- **WAIT**
  - On `tx_done_tick`: set `ptr = (sel+1) mod NREQ` and go to IDLE.
- **Requester contract**
  - Hold `req` and `din` stable until `ack`.
  - Deassert `req` the cycle after `ack`, or keep it high to queue another byte.
  - If `req` drops after selection, the latched byte is still sent and still acked.
- **Fairness**
  - `ptr` advances past the served requester.
  - With all requesters pending, grants cycle 0,1,…,NREQ-1,0.
  - The bound is one frame of waiting per other requester.
- **Ignored inputs**
  - `tx_done_tick` in IDLE or LAUNCH is ignored.
  - `s_tick` matters only in WAIT, and only with the timeout feature.
- **NREQ=1**
  - The search reduces to `req[0]`.
  - `grant_id` is a constant 0.

## Timing
- **Reset values:** state IDLE, `ptr=0`, `grant_id=0`, `tx_din=0`, `tx_start=0`, `ack=0`, `busy=0`, `timeout_err=0`, timeout counter 0.
- **Request latency:** `req` seen high in IDLE at edge N gives `tx_start`/`ack` high during cycle N+1, and `busy` high from N+1.
- **Registered outputs:** `tx_start`, `ack`, `busy` and `timeout_err` are Moore outputs decoded from registered state. They carry no combinational path from `req`.
- **Back-to-back frames:** `tx_done_tick` at edge M gives IDLE in cycle M+1 and the next `tx_start` in cycle M+2. The minimum gap is 2 cycles.
- **Reset mid-operation:** everything returns to reset values at once. Any frame in the TX core is abandoned by this block, no `ack` is reissued, and `ptr` returns to 0.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - A $clog2(TO_TICKS)-bit counter clears on entry to WAIT and increments on each `s_tick` in WAIT.
  - When the counter is at TO_TICKS-1 and `s_tick` arrives:
    - pulse `timeout_err` for one cycle;
    - advance `ptr` as on done;
    - go to IDLE.
  - If `tx_done_tick` and the terminal `s_tick` arrive in the same cycle, done wins and there is no `timeout_err`.
- **Undefined:**
  - There is no counter, `timeout_err` is tied to 0, and WAIT is left only on `tx_done_tick`.

## Test plan
- **Single request:** reset, then `req=4'b0100`, `din[23:16]=8'hA5`.
  - Expect `tx_start` and `ack=4'b0100` 1 cycle later, `tx_din=8'hA5`, `grant_id=2`.
  - After `tx_done_tick`, expect IDLE and `busy=0`.
- **Round-robin:** hold `req=4'b1111` with bytes 8'h10/11/12/13.
  - With `tx_done_tick` 20 cycles after each `tx_start`, expect grants 0,1,2,3,0.
  - Expect `tx_start` 2 cycles after each done.
- **Pointer wrap:** serve requester 3, then `req=4'b1001`.
  - Expect grant 0 before 3.
- **Early drop:** drop `req[1]` the cycle after selection.
  - Expect `tx_start` and `ack[1]` anyway, with the latched byte on `tx_din`.
- **Timeout (`UART_TX_ARB_TIMEOUT_EN`, TO_TICKS=16):** give no `tx_done_tick`.
  - Expect a `timeout_err` pulse on the 16th `s_tick` in WAIT, then IDLE and `ptr` advanced.
  - Repeat with done and the 16th tick coincident: expect no `timeout_err`.
- **Reset in WAIT:** assert `reset` during WAIT.
  - Expect all outputs at reset values immediately.
  - After release with `req=4'b0010`, expect grant 1 (`ptr=0`).
